// File: rtl/input_shift_register.sv
// Receive-side input shift register (ISR) for a PIO-style state machine.
// Accumulates IN bits, tracks the shift count and handles PUSH, MOV-to-ISR
// and autopush into the RX FIFO write port.
module input_shift_register (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [31:0] in_data,
  input  logic [5:0]  in_count,
  input  logic        shiftdir,
  input  logic        autopush_en,
  input  logic [5:0]  push_thresh,
  input  logic        push_req,
  input  logic        push_iffull,
  input  logic        push_block,
  input  logic        mov_load,
  input  logic [31:0] mov_data,
  input  logic        rx_full,
  output logic        rx_wr_en,
  output logic [31:0] rx_wr_data,
  output logic        stall,
  output logic [31:0] isr,
  output logic [5:0]  isr_count
);

  logic [31:0] isr_q, isr_d;
  logic [5:0]  cnt_q, cnt_d;

  // Decoded shift amount and threshold; 0 (and anything above 32) means 32.
  logic [5:0]  n_dec, t_dec;
  logic [4:0]  n_lo, n_inv;
  logic [31:0] in_mask, in_masked, shifted;
  logic [6:0]  cnt_sum;
  logic [5:0]  cnt_sat;
  logic        push_pending;

  // Decode operands and compute the shifted ISR value for an IN.
  always_comb begin
    n_dec = ((in_count == 6'd0) || (in_count > 6'd32)) ? 6'd32 : in_count;
    t_dec = ((push_thresh == 6'd0) || (push_thresh > 6'd32)) ? 6'd32 : push_thresh;
    // Shift amounts are kept to 5 bits; the n=32 case bypasses the shifters.
    n_lo  = n_dec[4:0];
    n_inv = 5'(6'd32 - n_dec);
    in_mask   = n_dec[5] ? 32'hFFFF_FFFF : ((32'd1 << n_lo) - 32'd1);
    in_masked = in_data & in_mask;
    if (n_dec[5]) begin
      shifted = in_data;
    end else if (shiftdir) begin
      shifted = (isr_q >> n_lo) | (in_masked << n_inv);
    end else begin
      shifted = (isr_q << n_lo) | in_masked;
    end
    cnt_sum = {1'b0, cnt_q} + {1'b0, n_dec};
    cnt_sat = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
    push_pending = autopush_en && (cnt_q >= t_dec);
  end

  // Command decode: mov_load > push_req > in_en; outputs and next state.
  always_comb begin
    isr_d      = isr_q;
    cnt_d      = cnt_q;
    rx_wr_en   = 1'b0;
    rx_wr_data = isr_q;
    stall      = 1'b0;
    if (!rst) begin
      isr_d      = 32'd0;
      cnt_d      = 6'd0;
      rx_wr_data = 32'd0;
    end else if (mov_load) begin
      isr_d = mov_data;
      cnt_d = 6'd0;
    end else if (push_req) begin
      if (push_iffull && (cnt_q < t_dec)) begin
        // IfFull with too few bits: no-op.
      end else if (!rx_full) begin
        rx_wr_en = 1'b1;
        isr_d    = 32'd0;
        cnt_d    = 6'd0;
      end else if (push_block) begin
        stall = 1'b1;
      end else begin
        // Full and non-blocking: data is dropped but the ISR still clears.
        isr_d = 32'd0;
        cnt_d = 6'd0;
      end
    end else if (in_en) begin
      if (push_pending) begin
        // A deferred autopush must drain before this IN can shift.
        stall = 1'b1;
        if (!rx_full) begin
          rx_wr_en = 1'b1;
          isr_d    = 32'd0;
          cnt_d    = 6'd0;
        end
      end else if (autopush_en && (cnt_sat >= t_dec) && !rx_full) begin
        rx_wr_en   = 1'b1;
        rx_wr_data = shifted;
        isr_d      = 32'd0;
        cnt_d      = 6'd0;
      end else begin
        isr_d = shifted;
        cnt_d = cnt_sat;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      isr_q <= 32'd0;
      cnt_q <= 6'd0;
    end else begin
      isr_q <= isr_d;
      cnt_q <= cnt_d;
    end
  end

  assign isr       = isr_q;
  assign isr_count = cnt_q;

endmodule

// File: tb/tb_input_shift_register.sv
// Directed self-checking bench for input_shift_register.
module tb_input_shift_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic [31:0] in_data;
  logic [5:0]  in_count;
  logic        shiftdir;
  logic        autopush_en;
  logic [5:0]  push_thresh;
  logic        push_req;
  logic        push_iffull;
  logic        push_block;
  logic        mov_load;
  logic [31:0] mov_data;
  logic        rx_full;
  logic        rx_wr_en;
  logic [31:0] rx_wr_data;
  logic        stall;
  logic [31:0] isr;
  logic [5:0]  isr_count;

  int n_pass = 0;
  int n_total = 0;
  int seen_wr;

  input_shift_register dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_data    (in_data),
    .in_count   (in_count),
    .shiftdir   (shiftdir),
    .autopush_en(autopush_en),
    .push_thresh(push_thresh),
    .push_req   (push_req),
    .push_iffull(push_iffull),
    .push_block (push_block),
    .mov_load   (mov_load),
    .mov_data   (mov_data),
    .rx_full    (rx_full),
    .rx_wr_en   (rx_wr_en),
    .rx_wr_data (rx_wr_data),
    .stall      (stall),
    .isr        (isr),
    .isr_count  (isr_count)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    in_en = 0; in_data = 0; in_count = 0; shiftdir = 0; autopush_en = 0;
    push_thresh = 0; push_req = 0; push_iffull = 0; push_block = 0;
    mov_load = 0; mov_data = 0; rx_full = 0;
  endtask

  // Advance one clock; leaves time 1 unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; in_en = 1; in_data = 32'hFFFF_FFFF; autopush_en = 1; push_req = 1; rx_full = 0;
    #1;
    n_total++;
    if (rx_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", rx_wr_en); else n_pass++;
    n_total++;
    if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
    n_total++;
    if (rx_wr_data !== 32'd0) $display("FAIL reset_wr_data got=%h exp=0", rx_wr_data);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'd0) $display("FAIL reset_isr got=%h exp=0", isr); else n_pass++;
    n_total++;
    if (isr_count !== 6'd0) $display("FAIL reset_count got=%0d exp=0", isr_count); else n_pass++;
    idle_inputs();
    rst = 1;
  endtask

  task automatic test_right_in();
    apply_reset();
    seen_wr = 0;
    in_en = 1; shiftdir = 1; in_count = 8; in_data = 32'hAB;
    #1; if (rx_wr_en) seen_wr++;
    tick();
    n_total++;
    if (isr !== 32'hAB00_0000) $display("FAIL right_in1_isr got=%h exp=ab000000", isr);
    else n_pass++;
    in_data = 32'hCD;
    #1; if (rx_wr_en) seen_wr++;
    tick();
    n_total++;
    if (isr !== 32'hCDAB_0000) $display("FAIL right_in2_isr got=%h exp=cdab0000", isr);
    else n_pass++;
    n_total++;
    if (isr_count !== 6'd16) $display("FAIL right_in_count got=%0d exp=16", isr_count);
    else n_pass++;
    n_total++;
    if (seen_wr !== 0) $display("FAIL right_in_nowrite got=%0d exp=0", seen_wr); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_autopush_left();
    logic [31:0] bytes [4];
    bytes = '{32'h11, 32'h22, 32'h33, 32'h44};
    apply_reset();
    in_en = 1; shiftdir = 0; in_count = 8; autopush_en = 1; push_thresh = 0;
    for (int i = 0; i < 3; i++) begin
      in_data = bytes[i];
      tick();
    end
    n_total++;
    if (isr !== 32'h0011_2233 || isr_count !== 6'd24)
      $display("FAIL left_acc got=%h/%0d exp=00112233/24", isr, isr_count);
    else n_pass++;
    in_data = bytes[3];
    #1;
    n_total++;
    if (rx_wr_en !== 1'b1 || rx_wr_data !== 32'h1122_3344 || stall !== 1'b0)
      $display("FAIL left_autopush got=%b/%h/%b exp=1/11223344/0", rx_wr_en, rx_wr_data, stall);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'd0 || isr_count !== 6'd0)
      $display("FAIL left_after_push got=%h/%0d exp=0/0", isr, isr_count);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_autopush_full();
    apply_reset();
    in_en = 1; shiftdir = 0; in_count = 8; autopush_en = 1; push_thresh = 8; rx_full = 1;
    in_data = 32'h5A;
    #1;
    n_total++;
    if (rx_wr_en !== 1'b0 || stall !== 1'b0)
      $display("FAIL full_first_in got=%b/%b exp=0/0", rx_wr_en, stall);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'h5A || isr_count !== 6'd8)
      $display("FAIL full_first_state got=%h/%0d exp=5a/8", isr, isr_count);
    else n_pass++;
    in_data = 32'h77;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if (stall !== 1'b1 || rx_wr_en !== 1'b0)
        $display("FAIL full_stall_%0d got=%b/%b exp=1/0", i, stall, rx_wr_en);
      else n_pass++;
      tick();
    end
    n_total++;
    if (isr !== 32'h5A || isr_count !== 6'd8)
      $display("FAIL full_held got=%h/%0d exp=5a/8", isr, isr_count);
    else n_pass++;
    rx_full = 0;
    #1;
    n_total++;
    if (rx_wr_en !== 1'b1 || rx_wr_data !== 32'h5A || stall !== 1'b1)
      $display("FAIL full_drain got=%b/%h/%b exp=1/5a/1", rx_wr_en, rx_wr_data, stall);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'd0 || isr_count !== 6'd0)
      $display("FAIL full_drained got=%h/%0d exp=0/0", isr, isr_count);
    else n_pass++;
    // The retried IN now reaches the threshold and pushes immediately.
    #1;
    n_total++;
    if (rx_wr_en !== 1'b1 || rx_wr_data !== 32'h77 || stall !== 1'b0)
      $display("FAIL full_retry got=%b/%h/%b exp=1/77/0", rx_wr_en, rx_wr_data, stall);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_push();
    apply_reset();
    in_en = 1; shiftdir = 0; in_count = 16; in_data = 32'h1234;
    tick();
    idle_inputs();
    push_req = 1; push_iffull = 1;
    #1;
    n_total++;
    if (rx_wr_en !== 1'b0 || stall !== 1'b0)
      $display("FAIL push_iffull got=%b/%b exp=0/0", rx_wr_en, stall);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'h1234 || isr_count !== 6'd16)
      $display("FAIL push_iffull_state got=%h/%0d exp=1234/16", isr, isr_count);
    else n_pass++;
    push_iffull = 0; rx_full = 1; push_block = 1;
    #1;
    n_total++;
    if (stall !== 1'b1 || rx_wr_en !== 1'b0)
      $display("FAIL push_block got=%b/%b exp=1/0", stall, rx_wr_en);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'h1234 || isr_count !== 6'd16)
      $display("FAIL push_block_state got=%h/%0d exp=1234/16", isr, isr_count);
    else n_pass++;
    push_block = 0;
    #1;
    n_total++;
    if (stall !== 1'b0 || rx_wr_en !== 1'b0)
      $display("FAIL push_noblock got=%b/%b exp=0/0", stall, rx_wr_en);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'd0 || isr_count !== 6'd0)
      $display("FAIL push_noblock_state got=%h/%0d exp=0/0", isr, isr_count);
    else n_pass++;
    idle_inputs();
    mov_load = 1; mov_data = 32'h55;
    tick();
    idle_inputs();
    push_req = 1;
    #1;
    n_total++;
    if (rx_wr_en !== 1'b1 || rx_wr_data !== 32'h55 || stall !== 1'b0)
      $display("FAIL push_plain got=%b/%h/%b exp=1/55/0", rx_wr_en, rx_wr_data, stall);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_mov_priority();
    apply_reset();
    mov_load = 1; push_req = 1; in_en = 1; mov_data = 32'hDEAD_BEEF;
    in_count = 8; in_data = 32'hFF;
    #1;
    n_total++;
    if (rx_wr_en !== 1'b0 || stall !== 1'b0)
      $display("FAIL mov_outputs got=%b/%b exp=0/0", rx_wr_en, stall);
    else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'hDEAD_BEEF || isr_count !== 6'd0)
      $display("FAIL mov_state got=%h/%0d exp=deadbeef/0", isr, isr_count);
    else n_pass++;
    idle_inputs();
    in_en = 1; in_count = 0; in_data = 32'hCAFE_F00D; shiftdir = 1;
    tick();
    n_total++;
    if (isr !== 32'hCAFE_F00D || isr_count !== 6'd32)
      $display("FAIL in32 got=%h/%0d exp=cafef00d/32", isr, isr_count);
    else n_pass++;
    in_count = 4; in_data = 32'hFFFF_FFFF;
    tick();
    n_total++;
    if (isr !== 32'hFCAF_EF00 || isr_count !== 6'd32)
      $display("FAIL in_saturate got=%h/%0d exp=fcafef00/32", isr, isr_count);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_stall();
    idle_inputs();
    push_req = 1; push_block = 1; rx_full = 1;
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL rst_stall_pre got=%b exp=1", stall); else n_pass++;
    rst = 0;
    #1;
    n_total++;
    if (stall !== 1'b0) $display("FAIL rst_stall_drop got=%b exp=0", stall); else n_pass++;
    tick();
    n_total++;
    if (isr !== 32'd0 || isr_count !== 6'd0)
      $display("FAIL rst_stall_state got=%h/%0d exp=0/0", isr, isr_count);
    else n_pass++;
    rst = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    #2;
    test_reset();
    test_right_in();
    test_autopush_left();
    test_autopush_full();
    test_push();
    test_mov_priority();
    test_reset_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_shift_register.md
Name: input_shift_register

Overview:
- Receive-side counterpart of the PIO output shift path: accumulates bits from IN instructions into a 32-bit ISR and tracks the shift count.
- Handles PUSH (iffull/block variants), MOV-to-ISR load, and autopush at a programmable threshold into the RX FIFO write port.
- Sits between the state-machine execute stage (control, stall feedback) and the RX FIFO.

Parameters:
- none. Width is fixed at 32.
- Encodings: count/threshold value 0 means 32.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset; asserted when 0, sampled on posedge clk
- in_en  in  1  execute IN this cycle
- in_data  in  32  IN source; only bits [n-1:0] are used
- in_count  in  6  bits to shift, n; 0 means 32
- shiftdir  in  1  1 = shift right (data enters at MSB end), 0 = shift left (data enters at LSB)
- autopush_en  in  1  autopush enable
- push_thresh  in  6  autopush/iffull threshold T; 0 means 32
- push_req  in  1  execute PUSH this cycle
- push_iffull  in  1  PUSH IfFull flag
- push_block  in  1  PUSH Block flag
- mov_load  in  1  execute MOV ISR, src this cycle
- mov_data  in  32  MOV source value
- rx_full  in  1  RX FIFO full
- rx_wr_en  out  1  RX FIFO write strobe; combinational
- rx_wr_data  out  32  RX FIFO write data; combinational
- stall  out  1  current instruction must re-execute next cycle; combinational
- isr  out  32  ISR contents; registered
- isr_count  out  6  bits shifted in since last clear, 0..32; registered

Behaviour:
- Reset (rst==0 at posedge): isr=0, isr_count=0. While rst==0, rx_wr_en=0, stall=0 and rx_wr_data=0.
- Priority when several commands are set: mov_load > push_req > in_en. Lower-priority commands are ignored that cycle.
- Idle (no command): no state change; rx_wr_en=0; stall=0.
- MOV: next isr=mov_data; next isr_count=0; stall=0; rx_wr_en=0.
- Shift, right (n = decoded in_count): new = (isr >> n) | (in_data[n-1:0] << (32-n)).
- Shift, left: new = (isr << n) | in_data[n-1:0].
- n=32 in either direction gives new=in_data. Shifts must be written width-safe, with no out-of-range shift amounts.
- IN, pending-push case (P = autopush_en && isr_count >= T):
  - stall=1; the ISR does not shift.
  - If rx_full=0: rx_wr_en=1, rx_wr_data=isr; next isr=0, isr_count=0.
  - If rx_full=1: no state change.
- IN, normal case (P false):
  - Compute new; c = min(isr_count+n, 32); stall=0.
  - If autopush_en && c >= T && rx_full=0: rx_wr_en=1, rx_wr_data=new; next isr=0, isr_count=0.
  - Otherwise: next isr=new, isr_count=c, and any pending push is deferred to the next IN (the pending-push case).
- PUSH:
  - If push_iffull && isr_count < T: no-op, stall=0.
  - Else if rx_full=0: rx_wr_en=1, rx_wr_data=isr; next isr=0, isr_count=0; stall=0.
  - Else if push_block: stall=1; no state change.
  - Else (full, non-blocking): no write; isr and isr_count still cleared; stall=0.
- rx_wr_en is never asserted while rx_full=1.
- isr_count saturates at 32 and never wraps.
- When rx_wr_en=0, rx_wr_data=isr (don't-care to consumers).
- Reset mid-stall: state clears; the stall drops the same cycle rst goes low.

Test Plan:
- Right IN, no autopush: reset; IN n=8 of 0xAB, then IN n=8 of 0xCD, shiftdir=1 -> isr=0xCDAB0000, isr_count=16, rx_wr_en never 1.
- Left autopush, T=32: four IN n=8 of 0x11, 0x22, 0x33, 0x44, shiftdir=0 -> 4th cycle rx_wr_en=1, rx_wr_data=0x11223344, stall=0; next cycle isr=0, count=0.
- Autopush into full FIFO, T=8, rx_full=1:
  - IN n=8 of 0x5A -> isr=0x5A, count=8, no write.
  - Next IN -> stall=1 held while full.
  - Drop rx_full -> write 0x5A with stall=1; following cycle the IN completes.
- PUSH variants, isr=0x1234, count=16, T=32:
  - push_iffull=1 -> no-op.
  - Plain PUSH with rx_full=1, block=1 -> stall=1, isr unchanged.
  - Same with block=0 -> no write, isr=0, count=0.
- MOV and priority:
  - mov_load=1 with push_req=1 and in_en=1, mov_data=0xDEADBEEF -> isr=0xDEADBEEF, count=0, rx_wr_en=0.
  - IN n=0 (32 bits) of 0xCAFEF00D -> isr=0xCAFEF00D, count=32.
- Reset during stall: blocked PUSH stalling, assert rst=0 for one cycle -> stall=0 that cycle; isr=0, count=0 after the edge.
